// File: rtl/uart_pkg.sv
// Shared types and constants for the UART level receiver.
// rx_state_t : receiver FSM states
// ASCII_*    : command characters understood by the level parser
// LEVEL_W    : width of the level output
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_F_UC  = 8'h46;
  localparam logic [7:0] ASCII_F_LC  = 8'h66;

  localparam int LEVEL_W = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a two-flop input synchroniser.
// clk          : system clock, rising edge
// rst          : synchronous active-high reset
// rx_i         : asynchronous serial line, idle high
// byte_o       : last correctly framed byte
// byte_valid_o : one-cycle pulse when byte_o updates
// frame_err_o  : one-cycle pulse when a stop bit is sampled low
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             sync_meta;
  logic             rxs;
  rx_state_t        state;
  rx_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_next;
  logic [7:0]       shift;
  logic [7:0]       shift_next;
  logic             load;
  logic             bad_stop;

  // Next-state logic. In WAIT_HIGH the counter measures a run of idle-high
  // cycles; elsewhere it measures the position inside the current bit.
  // START waits half a bit so every later sample lands mid-bit.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    load         = 1'b0;
    bad_stop     = 1'b0;
    unique case (state)
      WAIT_HIGH: begin
        if (!rxs) begin
          cnt_next = '0;
        end else if (cnt == FULL_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      IDLE: begin
        cnt_next = '0;
        if (!rxs) begin
          bit_idx_next = '0;
          state_next   = START;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_next   = '0;
          state_next = rxs ? IDLE : DATA;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_next   = '0;
          shift_next = {rxs, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_next = '0;
          if (rxs) begin
            load       = 1'b1;
            state_next = IDLE;
          end else begin
            bad_stop   = 1'b1;
            state_next = WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = WAIT_HIGH;
        cnt_next   = '0;
      end
    endcase
  end

  // State, datapath and output registers. The synchroniser resets to the
  // idle-high level so reset itself never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta    <= 1'b1;
      rxs          <= 1'b1;
      state        <= WAIT_HIGH;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      sync_meta    <= rx_i;
      rxs          <= sync_meta;
      state        <= state_next;
      cnt          <= cnt_next;
      bit_idx      <= bit_idx_next;
      shift        <= shift_next;
      byte_valid_o <= load;
      frame_err_o  <= bad_stop;
      if (load) begin
        byte_o <= shift;
      end
    end
  end

endmodule

// File: rtl/uart_level_rx.sv
// UART front end for the LED bar display: receives bytes and interprets
// ASCII level commands ('0'..'9', 'F'/'f', '+', '-').
// clk           : system clock, rising edge
// rst           : synchronous active-high reset
// rx_i          : asynchronous serial line, idle high
// byte_o        : last correctly framed byte
// byte_valid_o  : one-cycle pulse when byte_o updates
// frame_err_o   : one-cycle pulse on a bad stop bit
// level_o       : current level 0..LEVEL_MAX
// level_valid_o : one-cycle pulse on every level write
module uart_level_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int LEVEL_MAX = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_i,
  output logic [7:0]         byte_o,
  output logic               byte_valid_o,
  output logic               frame_err_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic               level_valid_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(LEVEL_MAX);

  logic [LEVEL_W-1:0] digit;
  logic [LEVEL_W-1:0] level_next;
  logic               level_write;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .frame_err_o  (frame_err_o)
  );

  // ASCII digits carry their value in the low nibble; clamp in case the
  // ceiling is configured below 9.
  assign digit = (byte_o[3:0] > LVL_MAX) ? LVL_MAX : byte_o[3:0];

  // Command decode for the byte just received; unknown bytes write nothing.
  always_comb begin
    level_next  = level_o;
    level_write = 1'b0;
    if (byte_valid_o) begin
      if (byte_o >= ASCII_0 && byte_o <= ASCII_9) begin
        level_next  = digit;
        level_write = 1'b1;
      end else if (byte_o == ASCII_F_UC || byte_o == ASCII_F_LC) begin
        level_next  = LVL_MAX;
        level_write = 1'b1;
      end else if (byte_o == ASCII_PLUS) begin
        level_next  = (level_o < LVL_MAX) ? level_o + LEVEL_W'(1) : LVL_MAX;
        level_write = 1'b1;
      end else if (byte_o == ASCII_MINUS) begin
        level_next  = (level_o != '0) ? level_o - LEVEL_W'(1) : '0;
        level_write = 1'b1;
      end
    end
  end

  // Level register; the pulse fires on every write, even if the value holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_o       <= '0;
      level_valid_o <= 1'b0;
    end else begin
      level_valid_o <= level_write;
      if (level_write) begin
        level_o <= level_next;
      end
    end
  end

endmodule

// File: tb/tb_uart_level_rx.sv
// Scoreboard bench for uart_level_rx at 16 clocks per bit. The stimulus
// side queues the expected outcome of every frame it sends; an independent
// monitor pops and compares whenever the DUT reports a byte or frame error,
// and checks the level write one cycle later.
module tb_uart_level_rx;

  localparam int CPB       = 16;
  localparam int LEVEL_MAX = 10;

  typedef struct {
    bit         err;
    logic [7:0] data;
    bit         cmd;
    int         lvl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_i;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       frame_err_o;
  logic [3:0] level_o;
  logic       level_valid_o;

  exp_t exp_q[$];
  exp_t pend;
  bit   pend_valid = 1'b0;
  int   exp_level  = 0;
  int   model_level = 0;
  int   checks = 0;
  int   errors = 0;

  uart_level_rx #(
    .CLK_FREQ  (16),
    .BAUD      (1),
    .LEVEL_MAX (LEVEL_MAX)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_i          (rx_i),
    .byte_o        (byte_o),
    .byte_valid_o  (byte_valid_o),
    .frame_err_o   (frame_err_o),
    .level_o       (level_o),
    .level_valid_o (level_valid_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference behaviour of the command parser in plain arithmetic.
  function automatic void refModel(input int cur, input logic [7:0] b,
                                   output bit cmd, output int nxt);
    cmd = 1'b1;
    nxt = cur;
    if (b >= "0" && b <= "9")      nxt = int'(b) - 48;
    else if (b == "F" || b == "f") nxt = LEVEL_MAX;
    else if (b == "+")             nxt = (cur + 1 > LEVEL_MAX) ? LEVEL_MAX : cur + 1;
    else if (b == "-")             nxt = (cur - 1 < 0) ? 0 : cur - 1;
    else                           cmd = 1'b0;
  endfunction

  task automatic holdLine(input logic v, input int n);
    rx_i = v;
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame (start, 8 data bits LSB first, stop) followed by an
  // idle-high gap, queueing what the DUT should report for it.
  task automatic applyStimulus(input logic [7:0] b, input bit stop_bit, input int gap);
    exp_t e;
    bit   cmd;
    int   nxt;
    if (stop_bit) begin
      refModel(model_level, b, cmd, nxt);
      if (cmd) model_level = nxt;
      e = '{err: 1'b0, data: b, cmd: cmd, lvl: nxt};
    end else begin
      e = '{err: 1'b1, data: b, cmd: 1'b0, lvl: model_level};
    end
    exp_q.push_back(e);
    holdLine(1'b0, CPB);
    for (int i = 0; i < 8; i++) holdLine(b[i], CPB);
    holdLine(stop_bit, CPB);
    holdLine(1'b1, gap);
  endtask

  // Reset clears the monitor's view of the level and any write in flight.
  always @(posedge clk) begin
    if (rst) begin
      pend_valid = 1'b0;
      exp_level  = 0;
    end
  end

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (pend_valid) begin
        checkOutput("level_valid after byte", int'(level_valid_o), int'(pend.cmd));
        if (pend.cmd) exp_level = pend.lvl;
        checkOutput("level value", int'(level_o), exp_level);
        pend_valid = 1'b0;
      end else if (level_valid_o) begin
        checkOutput("spurious level_valid", int'(level_valid_o), 0);
      end
      if (byte_valid_o || frame_err_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected byte_valid", int'(byte_valid_o), 0);
          checkOutput("unexpected frame_err", int'(frame_err_o), 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("frame_err", int'(frame_err_o), int'(e.err));
          checkOutput("byte_valid", int'(byte_valid_o), int'(!e.err));
          if (!e.err) begin
            checkOutput("byte", int'(byte_o), int'(e.data));
            pend       = e;
            pend_valid = 1'b1;
          end else begin
            checkOutput("level held on frame error", int'(level_o), exp_level);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] eight;
    logic [7:0] b;
    bit         stop_bit;
    int         gap;
    eight = 8'h38;
    rst   = 1'b1;
    rx_i  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset byte_o", int'(byte_o), 0);
    checkOutput("reset byte_valid_o", int'(byte_valid_o), 0);
    checkOutput("reset frame_err_o", int'(frame_err_o), 0);
    checkOutput("reset level_o", int'(level_o), 0);
    checkOutput("reset level_valid_o", int'(level_valid_o), 0);
    holdLine(1'b1, CPB);

    $display("[TB] basic digit");
    applyStimulus("7", 1'b1, 2 * CPB);

    $display("[TB] saturation");
    applyStimulus("9", 1'b1, CPB);
    applyStimulus("+", 1'b1, CPB);
    applyStimulus("+", 1'b1, CPB);
    applyStimulus("0", 1'b1, CPB);
    applyStimulus("-", 1'b1, CPB);

    $display("[TB] frame error then recovery");
    applyStimulus(8'h35, 1'b0, CPB);
    applyStimulus("3", 1'b1, CPB);

    $display("[TB] start-bit glitch");
    holdLine(1'b0, 4);
    holdLine(1'b1, CPB);
    applyStimulus("2", 1'b1, CPB);

    // Reset lands mid bit 3 of '8'. Bits 3..5 are high, which satisfies the
    // idle-high wait, so the low bit 6 is then taken as a start bit: the
    // tail decodes as 0xFE (bit 7 low, stop and idle high), a non-command
    // byte that leaves the level at its reset value.
    $display("[TB] reset mid-frame");
    holdLine(1'b0, CPB);
    for (int i = 0; i < 3; i++) holdLine(eight[i], CPB);
    holdLine(eight[3], 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_level = 0;
    checkOutput("level after mid-frame reset", int'(level_o), 0);
    checkOutput("byte_o after mid-frame reset", int'(byte_o), 0);
    exp_q.push_back('{err: 1'b0, data: 8'hFE, cmd: 1'b0, lvl: 0});
    holdLine(eight[3], 7);
    for (int i = 4; i < 8; i++) holdLine(eight[i], CPB);
    holdLine(1'b1, CPB);
    holdLine(1'b1, 10 * CPB);
    applyStimulus("6", 1'b1, CPB);

    $display("[TB] non-command byte and back-to-back frames");
    applyStimulus("4", 1'b1, CPB);
    applyStimulus("x", 1'b1, CPB);
    applyStimulus("1", 1'b1, 0);
    applyStimulus("5", 1'b1, CPB);

    $display("[TB] randomized frames");
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0, 1:    b = 8'h30 + 8'($urandom_range(0, 9));
        2:       b = "+";
        3:       b = "-";
        4:       b = ($urandom_range(0, 1) != 0) ? "F" : "f";
        default: b = 8'($urandom_range(0, 255));
      endcase
      stop_bit = ($urandom_range(0, 7) != 0);
      gap = stop_bit ? int'($urandom_range(0, 24)) : CPB + int'($urandom_range(0, 8));
      applyStimulus(b, stop_bit, gap);
    end

    holdLine(1'b1, 4 * CPB);
    checkOutput("expected events outstanding", exp_q.size(), 0);
    checkOutput("level write outstanding", int'(pend_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
